// File: rtl/mult_arbiter_if.sv
// Bundle of requester, response and shared-multiplier signals for mult_arbiter.
// Latency: none; this is wiring only.
// Backpressure: none here; the arbiter holds requesters off through its grant pulses.
interface mult_arbiter_if #(
    parameter int W = 256
);
    logic             req0;
    logic             req1;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [2*W-1:0]   product;
    logic             err;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_start;
    logic [2*W-1:0]   mul_product;
    logic             mul_done;

    // Arbiter side
    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_product, mul_done,
        output gnt0, gnt1, done0, done1, product, err, mul_a, mul_b, mul_start
    );

    // Requester / multiplier side
    modport master (
        output req0, req1, a0, b0, a1, b1, mul_product, mul_done,
        input  gnt0, gnt1, done0, done1, product, err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between two requesters.
// Latency: gnt at G, mul_start at G+1, doneN one cycle after mul_done rises; err TIMEOUT cycles after mul_start.
// Backpressure: requests are held off (no grant) until the FSM is back in IDLE; nothing is dropped.
module mult_arbiter #(
    parameter int W       = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_arbiter_if.slave  bus
);
    // Counter only needs to reach TIMEOUT-1 before the abort fires.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic              mul_start_q, mul_start_d;
    logic [W-1:0]      mul_a_q, mul_a_d;
    logic [W-1:0]      mul_b_q, mul_b_d;
    logic [2*W-1:0]    product_q, product_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dsamp_q, dsamp_d;   // previous mul_done level
    logic              last_q, last_d;     // requester served most recently
    logic              owner_q, owner_d;   // requester of the in-flight multiply
    logic              win;
    logic              done_rise;

    assign done_rise = bus.mul_done & ~dsamp_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        product_d   = product_q;
        cnt_d       = cnt_q;
        dsamp_d     = bus.mul_done;
        last_d      = last_q;
        owner_d     = owner_q;
        win         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester not served last wins.
                    win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    owner_d = win;
                    last_d  = win;
                    mul_a_d = win ? bus.a1 : bus.a0;
                    mul_b_d = win ? bus.b1 : bus.b0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    state_d = START;
                end
            end
            START: begin
                mul_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    product_d = bus.mul_product;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    state_d   = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            product_q   <= '0;
            cnt_q       <= '0;
            dsamp_q     <= 1'b0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err_q       <= err_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            product_q   <= product_d;
            cnt_q       <= cnt_d;
            dsamp_q     <= dsamp_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: grants, round-robin, wide product, timeout, stale done, reset abort.
// Latency: checks exact cycle positions of gnt, mul_start, done and err.
// Backpressure: requests are held until grant and dropped on the grant cycle.
module tb_mult_arbiter;
    localparam int W  = 256;
    localparam int TO = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult_arbiter_if #(.W(W)) bus ();

    mult_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete multiply: wait for grant, check operands and start, complete after a stale-done phase.
    task automatic txn(input string tag, input logic who, input logic [W-1:0] ea,
                       input logic [W-1:0] eb, input logic [2*W-1:0] ep);
        int n;
        n = 0;
        while (!(bus.gnt0 || bus.gnt1) && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_gnt"}, 512'(who ? bus.gnt1 : bus.gnt0), 512'(1));
        chk({tag, "_gnt_excl"}, 512'(bus.gnt0 & bus.gnt1), 512'(0));
        if (who) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
        chk({tag, "_start_at_g"}, 512'(bus.mul_start), 512'(0));
        tick();
        chk({tag, "_start_g1"}, 512'(bus.mul_start), 512'(1));
        chk({tag, "_mul_a"}, 512'(bus.mul_a), 512'(ea));
        chk({tag, "_mul_b"}, 512'(bus.mul_b), 512'(eb));
        if (who) begin bus.a1 = '1; bus.b1 = '1; end
        else     begin bus.a0 = '1; bus.b0 = '1; end
        tick();
        chk({tag, "_start_pulse"}, 512'(bus.mul_start), 512'(0));
        repeat (2) tick();
        chk({tag, "_no_early_done"}, 512'(bus.done0 | bus.done1 | bus.err), 512'(0));
        bus.mul_done = 1'b0;
        tick();
        bus.mul_product = 512'(bus.mul_a) * 512'(bus.mul_b);
        bus.mul_done    = 1'b1;
        tick();
        chk({tag, "_done"}, 512'(who ? bus.done1 : bus.done0), 512'(1));
        chk({tag, "_done_other"}, 512'(who ? bus.done0 : bus.done1), 512'(0));
        chk({tag, "_product"}, 512'(bus.product), 512'(ep));
        chk({tag, "_err_lo"}, 512'(bus.err), 512'(0));
        tick();
        chk({tag, "_done_pulse"}, 512'(bus.done0 | bus.done1), 512'(0));
    endtask

    initial begin
        logic [W-1:0]   big_a;
        logic [W-1:0]   qm1;
        logic [2*W-1:0] big_p;
        logic           seen;
        int             n;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.mul_product = '0; bus.mul_done = 1'b0;

        // Reset values, then first grant on the first edge after release
        bus.req0 = 1'b1; bus.a0 = 256'd3; bus.b0 = 256'd5;
        repeat (2) tick();
        chk("rst_ctrl", 512'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mul_start}), 512'(0));
        chk("rst_product", 512'(bus.product), 512'(0));
        chk("rst_mul_ab", 512'({bus.mul_a, bus.mul_b}), 512'(0));
        rst_n = 1'b1;
        tick();
        chk("first_gnt_edge", 512'(bus.gnt0), 512'(1));
        txn("t3x5", 1'b0, 256'd3, 256'd5, 512'd15);

        // Tie from reset: 0 first, then 1; repeat tie goes to 0 again
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 256'd2; bus.b0 = 256'd7;
        bus.req1 = 1'b1; bus.a1 = 256'd4; bus.b1 = 256'd9;
        txn("tie_r0", 1'b0, 256'd2, 256'd7, 512'd14);
        txn("tie_r1", 1'b1, 256'd4, 256'd9, 512'd36);
        bus.req0 = 1'b1; bus.a0 = 256'd10; bus.b0 = 256'd11;
        bus.req1 = 1'b1; bus.a1 = 256'd12; bus.b1 = 256'd13;
        txn("tie2_r0", 1'b0, 256'd10, 256'd11, 512'd110);
        txn("tie2_r1", 1'b1, 256'd12, 256'd13, 512'd156);
        bus.req1 = 1'b1; bus.a1 = 256'd6; bus.b1 = 256'd7;
        txn("solo_r1", 1'b1, 256'd6, 256'd7, 512'd42);

        // Full-width product: 2^255 * (2^255 - 20)
        big_a = 256'd1 << 255;
        qm1   = (256'd1 << 255) - 256'd20;
        big_p = {256'd0, qm1} << 255;
        bus.req0 = 1'b1; bus.a0 = big_a; bus.b0 = qm1;
        txn("wide", 1'b0, big_a, qm1, big_p);

        // Timeout: mul_done never rises
        bus.mul_done = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.a0 = 256'd1; bus.b0 = 256'd1;
        n = 0;
        while (!bus.gnt0 && n < 50) begin tick(); n++; end
        chk("to_gnt", 512'(bus.gnt0), 512'(1));
        bus.req0 = 1'b0;
        tick();
        chk("to_start", 512'(bus.mul_start), 512'(1));
        seen = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            seen = seen | bus.err | bus.done0 | bus.done1;
        end
        chk("to_no_early_err", 512'(seen), 512'(0));
        tick();
        chk("to_err", 512'(bus.err), 512'(1));
        chk("to_no_done", 512'(bus.done0 | bus.done1), 512'(0));
        chk("to_product_kept", 512'(bus.product), 512'(big_p));
        bus.req1 = 1'b1; bus.a1 = 256'd5; bus.b1 = 256'd5;
        tick();
        chk("to_err_pulse", 512'(bus.err), 512'(0));
        txn("after_to", 1'b1, 256'd5, 256'd5, 512'd25);

        // Reset during WAIT for requester 1
        bus.req1 = 1'b1; bus.a1 = 256'd11; bus.b1 = 256'd13;
        n = 0;
        while (!bus.gnt1 && n < 50) begin tick(); n++; end
        chk("ra_gnt", 512'(bus.gnt1), 512'(1));
        bus.req1 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("ra_ctrl_zero", 512'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mul_start}), 512'(0));
        chk("ra_product_zero", 512'(bus.product), 512'(0));
        chk("ra_mul_ab_zero", 512'({bus.mul_a, bus.mul_b}), 512'(0));
        tick();
        rst_n = 1'b1;
        bus.mul_done = 1'b0;
        tick();
        bus.mul_product = 512'd143;
        bus.mul_done = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | bus.done0 | bus.done1;
        end
        chk("ra_no_stale_done", 512'(seen), 512'(0));
        bus.req1 = 1'b1; bus.a1 = 256'd3; bus.b1 = 256'd4;
        txn("ra_fresh", 1'b1, 256'd3, 256'd4, 512'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
